modu_expo_seq: RTL and testbench
================================

Name: modu_expo_seq

Overview:
- Parametrised modular exponentiation engine, computing r = b^e mod m.
- Scans the exponent left-to-right (square-and-multiply) through one shared internal radix-2 interleaved modular multiplier (Blakley): one bit per cycle, add-then-reduce.
- Generalises operand and exponent widths independently, reduces unreduced bases, and flags degenerate moduli.
- Serves as the exponentiation core beneath the RSA accelerator's Wishbone register front end.

Parameters:
NLEN, 32, width of b, m, r and of the multiplier datapath
EW, NLEN, exponent width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
strobe  input  1  start pulse; b/e/m sampled when strobe=1 and busy=0
b  input  NLEN  base; any value, may be >= m
e  input  EW  exponent
m  input  NLEN  modulus
r  output  NLEN  result; held from ready until next accepted strobe
ready  output  1  one-cycle completion pulse
busy  output  1  high from cycle after accepted strobe through the ready cycle minus one
err  output  1  pulses with ready when m==0

Behaviour:
- Reset (rst_n=0 at clk edge): r=0, ready=0, busy=0, err=0, FSM=IDLE, multiplier cleared. Applies mid-operation; no ready is produced for the aborted job.
- Operands: strobe with busy=0 latches b, e and m; busy=1 next cycle. Strobe while busy=1 is ignored and leaves the running job untouched.
- FSM: IDLE -> CHECK -> REDUCE -> LOOP (SQR/MUL) -> DONE -> IDLE.
- CHECK (1 cycle), degenerate moduli:
  - m==0: r=0, err=1, ready=1 next cycle.
  - m==1: r=0, err=0, ready=1 next cycle.
  - These cases have latency 2 (strobe edge to ready edge).
- Multiplier op computes x*y mod m, with precondition acc < m and y < m:
  - 1 load cycle plus NLEN iterate cycles = NLEN+1 cycles.
  - Each iterate step: acc = 2*acc + (x[i] ? y : 0), with i from NLEN-1 down to 0, then subtract m up to twice so that acc < m.
  - acc width is NLEN+2 bits; no overflow permitted.
- REDUCE: one multiplier op with x=b, y=1 gives bm = b mod m. Valid because m >= 2.
- Default (constant-time) LOOP:
  - r_acc starts at 1.
  - For each bit i from EW-1 down to 0: SQR r_acc = r_acc*r_acc, then MUL t = r_acc*bm. r_acc takes t only if e[i]=1; otherwise t is discarded.
  - Both ops always run.
- DONE: r <= r_acc, ready=1 for 1 cycle, busy=0 in the same cycle ready is high.
- Latency, strobe edge to ready edge, m >= 2: L = 2 + (2*EW+1)*(NLEN+1), independent of e and b.
- e==0 (m >= 2): r=1.
- ready and err are never high outside DONE or CHECK completion. r is stable while busy.

Optional Feature:
- Macro MODEXP_LEADZERO_SKIP_EN.
- When defined:
  - CHECK computes k = index of the MSB of e, plus 1, using a combinational priority encoder (no extra cycles).
  - e==0 (m >= 2) completes with r=1 at latency 2.
  - Otherwise r_acc starts at bm after REDUCE. Bits k-2..0 each run SQR, and MUL only when the bit is 1.
  - L = 2 + (NLEN+1)*(1 + (k-1) + (popcount(e)-1)).
- When undefined: constant-time behaviour as above. The priority encoder is absent.

Test Plan:
- NLEN=32, EW=32, b=4, e=13, m=497 -> r=445. ready exactly 2147 cycles after strobe (default), or 200 cycles (MODEXP_LEADZERO_SKIP_EN).
- b=502, e=13, m=497 (unreduced base) -> r=54. Also b=2, e=32, m=0xFFFFFFFF -> r=1.
- e=0, b=7, m=11 -> r=1, err=0. Latency 2147 (default) or 2 (skip).
- m=0 -> r=0, err=1, ready at latency 2. m=1, b=9, e=5 -> r=0, err=0, latency 2.
- Strobe with new operands 100 cycles into a job -> ignored; first job returns its own result with unchanged latency. A later strobe after ready is accepted.
- rst_n=0 for 1 cycle mid-job -> busy=0, r=0, no ready. A fresh strobe then completes correctly: b=3, e=5, m=7 -> r=5.

Source files
------------

// File: rtl/modu_expo_seq.sv
// ============================================================================
//  Module      : modu_expo_seq
//  Description : Sequential modular exponentiation engine, r = b^e mod m.
//                Scans the exponent MSB-first (square-and-multiply) through a
//                single shared radix-2 interleaved (Blakley) modular
//                multiplier that consumes one multiplier bit per cycle.
//                Optional build macro MODEXP_LEADZERO_SKIP_EN skips leading
//                zero exponent bits and MUL steps for zero bits (variable
//                time). Without it, every exponent bit costs SQR + MUL.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modu_expo_seq #(
    parameter int NLEN = 32,
    parameter int EW   = NLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            strobe,
    input  logic [NLEN-1:0] b,
    input  logic [EW-1:0]   e,
    input  logic [NLEN-1:0] m,
    output logic [NLEN-1:0] r,
    output logic            ready,
    output logic            busy,
    output logic            err
);

    localparam int CW = $clog2(NLEN + 1);
    localparam int BW = $clog2(EW + 1);

    localparam logic [CW-1:0]   C_LAST = CW'(NLEN);
    localparam logic [BW-1:0]   C_EW   = BW'(EW);
    localparam logic [BW-1:0]   C_BONE = BW'(1);
    localparam logic [NLEN-1:0] C_ONE  = NLEN'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REDUCE = 3'd2,
        S_SQR    = 3'd3,
        S_MUL    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [NLEN-1:0] b_q, b_d;
    logic [EW-1:0]   e_q, e_d;      // exponent, shifted left as bits are consumed
    logic [NLEN-1:0] m_q, m_d;
    logic [NLEN-1:0] bm_q, bm_d;    // base reduced modulo m
    logic [NLEN-1:0] racc_q, racc_d;
    logic [NLEN-1:0] r_q, r_d;
    logic [BW-1:0]   bits_q, bits_d; // exponent bits still to process
    logic            err_q, err_d;

    // Blakley multiplier state
    logic [NLEN+1:0] acc_q, acc_d;
    logic [NLEN-1:0] x_q, x_d;
    logic [NLEN-1:0] y_q, y_d;
    logic [CW-1:0]   cnt_q, cnt_d;  // 0 = load cycle, 1..NLEN = iterate cycles

    logic [NLEN+1:0] w_mx;
    logic [NLEN+1:0] w_add;
    logic [NLEN+1:0] w_sum;
    logic [NLEN+1:0] w_s1;
    logic [NLEN+1:0] w_acc_nx;
    logic [NLEN-1:0] w_res;
    logic [NLEN-1:0] w_ldx;
    logic [NLEN-1:0] w_ldy;

    // One Blakley step: 2*acc + (x bit ? y : 0), then at most two subtractions of m.
    // With acc < m and y < m the sum stays below 3m, which fits in NLEN+2 bits.
    assign w_mx     = {2'b00, m_q};
    assign w_add    = x_q[NLEN-1] ? {2'b00, y_q} : '0;
    assign w_sum    = (acc_q << 1) + w_add;
    assign w_s1     = (w_sum >= w_mx) ? (w_sum - w_mx) : w_sum;
    assign w_acc_nx = (w_s1 >= w_mx) ? (w_s1 - w_mx) : w_s1;
    assign w_res    = w_acc_nx[NLEN-1:0];

    // Operand selection for the load cycle of each multiplier operation
    always_comb begin
        w_ldx = racc_q;
        w_ldy = racc_q;
        case (state_q)
            S_REDUCE: begin
                w_ldx = b_q;
                w_ldy = C_ONE;
            end
            S_MUL: begin
                w_ldx = racc_q;
                w_ldy = bm_q;
            end
            default: begin
                w_ldx = racc_q;
                w_ldy = racc_q;
            end
        endcase
    end

`ifdef MODEXP_LEADZERO_SKIP_EN
    logic [BW-1:0] w_k;

    // Priority encoder: w_k = index of the exponent MSB plus one (0 when e == 0)
    always_comb begin
        w_k = '0;
        for (int i = 0; i < EW; i++) begin
            if (e_q[i]) begin
                w_k = BW'(i + 1);
            end
        end
    end
`endif

    // Next-state and datapath control for the exponentiation sequencer
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        e_d     = e_q;
        m_d     = m_q;
        bm_d    = bm_q;
        racc_d  = racc_q;
        r_d     = r_q;
        bits_d  = bits_q;
        err_d   = err_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    b_d     = b;
                    e_d     = e;
                    m_d     = m;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (m_q == '0) begin
                    err_d   = 1'b1;
                    racc_d  = '0;
                    state_d = S_DONE;
                end else if (m_q == C_ONE) begin
                    racc_d  = '0;
                    state_d = S_DONE;
                end else begin
`ifdef MODEXP_LEADZERO_SKIP_EN
                    if (e_q == '0) begin
                        racc_d  = C_ONE;
                        state_d = S_DONE;
                    end else begin
                        // Drop the leading one too: r_acc starts at bm after REDUCE
                        e_d     = (e_q << 1) << (C_EW - w_k);
                        bits_d  = w_k - C_BONE;
                        state_d = S_REDUCE;
                    end
`else
                    racc_d  = C_ONE;
                    bits_d  = C_EW;
                    state_d = S_REDUCE;
`endif
                end
            end

            S_REDUCE, S_SQR, S_MUL: begin
                if (cnt_q == '0) begin
                    x_d   = w_ldx;
                    y_d   = w_ldy;
                    acc_d = '0;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    acc_d = w_acc_nx;
                    x_d   = x_q << 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        cnt_d = '0;
                        if (state_q == S_REDUCE) begin
                            bm_d = w_res;
`ifdef MODEXP_LEADZERO_SKIP_EN
                            racc_d = w_res;
`endif
                            state_d = (bits_q == '0) ? S_DONE : S_SQR;
                        end else if (state_q == S_SQR) begin
                            racc_d = w_res;
`ifdef MODEXP_LEADZERO_SKIP_EN
                            if (e_q[EW-1]) begin
                                state_d = S_MUL;
                            end else begin
                                e_d     = e_q << 1;
                                bits_d  = bits_q - C_BONE;
                                state_d = (bits_q == C_BONE) ? S_DONE : S_SQR;
                            end
`else
                            state_d = S_MUL;
`endif
                        end else begin
                            // MUL always runs in constant-time mode; keep t only for a 1 bit
                            if (e_q[EW-1]) begin
                                racc_d = w_res;
                            end
                            e_d     = e_q << 1;
                            bits_d  = bits_q - C_BONE;
                            state_d = (bits_q == C_BONE) ? S_DONE : S_SQR;
                        end
                    end
                end
            end

            S_DONE: begin
                if (strobe) begin
                    b_d     = b;
                    e_d     = e;
                    m_d     = m;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The result register is loaded exactly on entry to DONE, so r is
        // valid together with ready and stays put until the next completion.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            r_d = racc_d;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            bm_q    <= '0;
            racc_q  <= '0;
            r_q     <= '0;
            bits_q  <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            e_q     <= e_d;
            m_q     <= m_d;
            bm_q    <= bm_d;
            racc_q  <= racc_d;
            r_q     <= r_d;
            bits_q  <= bits_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign r     = r_q;
    assign ready = (state_q == S_DONE);
    assign err   = (state_q == S_DONE) && err_q;
    assign busy  = (state_q == S_CHECK) || (state_q == S_REDUCE) ||
                   (state_q == S_SQR)   || (state_q == S_MUL);

endmodule

`default_nettype wire

// File: tb/tb_modu_expo_seq.sv
// ============================================================================
//  Module      : tb_modu_expo_seq
//  Description : Scoreboard bench for modu_expo_seq (NLEN = EW = 32) using
//                directed vectors with hand-computed results and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modu_expo_seq;

    localparam int NLEN = 32;
    localparam int EW   = 32;

`ifdef MODEXP_LEADZERO_SKIP_EN
    localparam int L_E13 = 200;
    localparam int L_E32 = 200;
    localparam int L_E0  = 2;
    localparam int L_E5  = 134;
`else
    localparam int L_E13 = 2147;
    localparam int L_E32 = 2147;
    localparam int L_E0  = 2147;
    localparam int L_E5  = 2147;
`endif
    localparam int L_DEG = 2;

    logic            clk;
    logic            rst_n;
    logic            strobe;
    logic [NLEN-1:0] b;
    logic [EW-1:0]   e;
    logic [NLEN-1:0] m;
    logic [NLEN-1:0] r;
    logic            ready;
    logic            busy;
    logic            err;

    modu_expo_seq #(
        .NLEN (NLEN),
        .EW   (EW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (strobe),
        .b      (b),
        .e      (e),
        .m      (m),
        .r      (r),
        .ready  (ready),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NLEN-1:0] r;
        logic            err;
        int              lat;
        int              strobe_edge;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    logic prev_ready = 1'b0;

    // Count rising edges so latency is measured edge to edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [NLEN-1:0] act, input logic [NLEN-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: pop the expected entry whenever the DUT presents ready
    always @(negedge clk) begin
        if (ready) begin
            if (prev_ready) begin
                n_vec++;
                n_bad++;
                $display("FAIL ready_width: ready high for more than one cycle");
            end else if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_ready: got ready with r=%0d, expected no ready", r);
            end else begin
                mx = sb.pop_front();
                chk("result_r", r, mx.r);
                chk("result_err", {31'd0, err}, {31'd0, mx.err});
                chk("busy_at_ready", {31'd0, busy}, 32'd0);
                chk("latency", NLEN'(cyc + 1 - mx.strobe_edge), NLEN'(mx.lat));
            end
        end
        prev_ready = ready;
    end

    // Present one strobe from a negedge; optionally record the expected response
    task automatic issue(input logic [NLEN-1:0] vb, input logic [EW-1:0] ve,
                         input logic [NLEN-1:0] vm, input logic [NLEN-1:0] er,
                         input logic eerr, input int elat, input bit push);
        b      = vb;
        e      = ve;
        m      = vm;
        strobe = 1'b1;
        if (push) sb.push_back('{er, eerr, elat, cyc + 1});
        @(negedge clk);
        strobe = 1'b0;
        b      = '1;
        e      = '1;
        m      = '1;
        chk("busy_after_strobe", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 6000) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got no ready within 6000 cycles, expected completion");
            sb.delete();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        strobe = 1'b0;
        b      = '0;
        e      = '0;
        m      = '0;
        repeat (3) @(negedge clk);
        chk("reset_r", r, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Main vector, with a strobe 100 cycles in that must be ignored
        issue(32'd4, 32'd13, 32'd497, 32'd445, 1'b0, L_E13, 1'b1);
        repeat (98) @(negedge clk);
        issue(32'd9, 32'd3, 32'd11, 32'd0, 1'b0, 0, 1'b0);
        wait_done();

        // Accepted immediately after ready (unreduced base)
        issue(32'd502, 32'd13, 32'd497, 32'd54, 1'b0, L_E13, 1'b1);
        wait_done();
        @(negedge clk);

        issue(32'd2, 32'd32, 32'hFFFF_FFFF, 32'd1, 1'b0, L_E32, 1'b1);
        wait_done();
        @(negedge clk);

        issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b1, L_DEG, 1'b1);
        wait_done();
        @(negedge clk);

        issue(32'd9, 32'd5, 32'd1, 32'd0, 1'b0, L_DEG, 1'b1);
        wait_done();
        @(negedge clk);

        issue(32'd7, 32'd0, 32'd11, 32'd1, 1'b0, L_E0, 1'b1);
        wait_done();
        @(negedge clk);
        chk("r_held_after_done", r, 32'd1);

        // Abort a job with a one-cycle reset
        issue(32'd3, 32'd5, 32'd7, 32'd0, 1'b0, 0, 1'b0);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_r", r, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        repeat (40) @(negedge clk);

        issue(32'd3, 32'd5, 32'd7, 32'd5, 1'b0, L_E5, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
